// File: rtl/exec_wb_arb_pkg.sv
// Shared backend types for the execute-to-writeback result path.
// Holds the writeback result payload, default field widths and a small index-width helper.
// No logic; imported by the result FIFO and the writeback arbiter.
package exec_wb_arb_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_PREG_W = 7;
   localparam int DEF_ROB_W  = 6;

   // One completed result headed for the physical register file.
   typedef struct packed {
      logic [DEF_PREG_W-1:0] preg;
      logic [DEF_DATA_W-1:0] data;
      logic [DEF_ROB_W-1:0]  rob;
   } wb_result_t;

   // Width of an index into n entries; never less than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/exec_wb_arb_fifo.sv
// Purpose: per-FU result queue of QDEPTH entries, generic payload type T.
// Latency: a pushed entry is visible at head_dat in the cycle after the push edge.
// Backpressure: push is ignored while full (even in a pop cycle); rst and flush empty the queue.
// Ports: clk/rst/flush; push + push_dat; pop; head_dat (oldest entry); count (occupancy).
module fu_result_fifo
   import exec_wb_arb_pkg::*;
#(
   parameter int  QDEPTH = 2,
   parameter type T      = wb_result_t
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  T                             push_dat,
   input  logic                         pop,
   output T                             head_dat,
   output logic [$clog2(QDEPTH+1)-1:0] count
);

   localparam int PTR_W = idx_width(QDEPTH);
   localparam int CNT_W = $clog2(QDEPTH+1);

   T                 mem [QDEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Fullness comes from the registered count, so a full queue cannot
   // accept even when its head is popped in the same cycle.
   assign full     = (count == CNT_W'(QDEPTH));
   assign do_push  = push && !full;
   assign do_pop   = pop && (count != '0);
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage needs no reset: entries are only read while counted.
   always_ff @(posedge clk) begin
      if (do_push && !rst && !flush) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/exec_wb_arb.sv
// Purpose: merge NUM_FU result channels onto NUM_WB register-file write ports, round-robin.
// Latency: 2 cycles from fu_valid accept to wb_valid (queue, then arbitrate and register).
// Backpressure: fu_ready[i] drops while FU i's queue is full; flush/rst discard all queued results.
// Ports: clk, rst (sync, active high), flush; fu_valid/fu_ready/fu_preg/fu_data/fu_rob per FU
//        (flat vectors, FU i at slice i); wb_valid/wb_preg/wb_data/wb_rob per write port.
module exec_wb_arb
   import exec_wb_arb_pkg::*;
#(
   parameter int NUM_FU = 4,
   parameter int NUM_WB = 3,
   parameter int QDEPTH = 2,
   parameter int DATA_W = DEF_DATA_W,
   parameter int PREG_W = DEF_PREG_W,
   parameter int ROB_W  = DEF_ROB_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [NUM_FU-1:0]        fu_valid,
   output logic [NUM_FU-1:0]        fu_ready,
   input  logic [NUM_FU*PREG_W-1:0] fu_preg,
   input  logic [NUM_FU*DATA_W-1:0] fu_data,
   input  logic [NUM_FU*ROB_W-1:0]  fu_rob,
   output logic [NUM_WB-1:0]        wb_valid,
   output logic [NUM_WB*PREG_W-1:0] wb_preg,
   output logic [NUM_WB*DATA_W-1:0] wb_data,
   output logic [NUM_WB*ROB_W-1:0]  wb_rob
);

   localparam int RR_W  = idx_width(NUM_FU);
   localparam int CNT_W = $clog2(QDEPTH+1);

   // Same layout as wb_result_t, sized by this instance's parameters.
   typedef struct packed {
      logic [PREG_W-1:0] preg;
      logic [DATA_W-1:0] data;
      logic [ROB_W-1:0]  rob;
   } res_t;

   res_t             q_in    [NUM_FU];
   res_t             q_head  [NUM_FU];
   logic [CNT_W-1:0] q_cnt   [NUM_FU];
   logic [NUM_FU-1:0] q_push;
   logic [NUM_FU-1:0] q_pop;
   logic [NUM_FU-1:0] q_nonempty;

   logic [RR_W-1:0]   rr_ptr;
   logic [RR_W-1:0]   rr_nxt;
   logic [NUM_WB-1:0] gnt_vld;
   res_t              gnt_dat [NUM_WB];
   logic              any_gnt;

   for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
      assign q_in[i]       = '{preg: fu_preg[i*PREG_W +: PREG_W],
                               data: fu_data[i*DATA_W +: DATA_W],
                               rob:  fu_rob[i*ROB_W +: ROB_W]};
      assign fu_ready[i]   = (q_cnt[i] < CNT_W'(QDEPTH));
      assign q_nonempty[i] = (q_cnt[i] != '0);
      assign q_push[i]     = fu_valid[i] && fu_ready[i];

      fu_result_fifo #(
         .QDEPTH (QDEPTH),
         .T      (res_t)
      ) u_fifo (
         .clk      (clk),
         .rst      (rst),
         .flush    (flush),
         .push     (q_push[i]),
         .push_dat (q_in[i]),
         .pop      (q_pop[i]),
         .head_dat (q_head[i]),
         .count    (q_cnt[i])
      );
   end

   // Position of FU i in this cycle's scan order, 0 being the rr_ptr FU.
   function automatic int rot_pos(input int i, input int rr);
      return (i - rr + NUM_FU) % NUM_FU;
   endfunction

   // Each non-empty FU's rank is the number of non-empty FUs ahead of it in
   // scan order; ranks below NUM_WB are granted and rank k drives port k.
   always_comb begin
      int rank;
      int best_pos;
      int last_idx;
      q_pop    = '0;
      gnt_vld  = '0;
      any_gnt  = 1'b0;
      best_pos = -1;
      last_idx = 0;
      for (int k = 0; k < NUM_WB; k++) gnt_dat[k] = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         rank = 0;
         for (int f = 0; f < NUM_FU; f++) begin
            if (q_nonempty[f] && (rot_pos(f, int'(rr_ptr)) < rot_pos(i, int'(rr_ptr))))
               rank = rank + 1;
         end
         if (q_nonempty[i] && (rank < NUM_WB)) begin
            q_pop[i] = 1'b1;
            any_gnt  = 1'b1;
            for (int k = 0; k < NUM_WB; k++) begin
               if (rank == k) begin
                  gnt_vld[k] = 1'b1;
                  gnt_dat[k] = q_head[i];
               end
            end
            if (rot_pos(i, int'(rr_ptr)) > best_pos) begin
               best_pos = rot_pos(i, int'(rr_ptr));
               last_idx = i;
            end
         end
      end
      rr_nxt = RR_W'((last_idx + 1) % NUM_FU);
   end

   // Payload fields are only loaded on a grant; idle ports keep old values.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr   <= '0;
         wb_valid <= '0;
         wb_preg  <= '0;
         wb_data  <= '0;
         wb_rob   <= '0;
      end else if (flush) begin
         rr_ptr   <= '0;
         wb_valid <= '0;
      end else begin
         wb_valid <= gnt_vld;
         if (any_gnt) rr_ptr <= rr_nxt;
         for (int k = 0; k < NUM_WB; k++) begin
            if (gnt_vld[k]) begin
               wb_preg[k*PREG_W +: PREG_W] <= gnt_dat[k].preg;
               wb_data[k*DATA_W +: DATA_W] <= gnt_dat[k].data;
               wb_rob[k*ROB_W +: ROB_W]    <= gnt_dat[k].rob;
            end
         end
      end
   end

endmodule

// File: tb/tb_exec_wb_arb.sv
// Purpose: directed self-checking bench for exec_wb_arb at default parameters.
// Latency: inputs driven 1 time unit after posedge, outputs sampled at negedge.
// Backpressure: the stream phase follows fu_ready to decide which offers were accepted.
module tb_exec_wb_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [3:0]  fu_valid;
   logic [3:0]  fu_ready;
   logic [27:0] fu_preg;
   logic [127:0] fu_data;
   logic [23:0] fu_rob;
   logic [2:0]  wb_valid;
   logic [20:0] wb_preg;
   logic [95:0] wb_data;
   logic [17:0] wb_rob;

   int n_cmp = 0;
   int n_bad = 0;

   exec_wb_arb dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .fu_valid (fu_valid),
      .fu_ready (fu_ready),
      .fu_preg  (fu_preg),
      .fu_data  (fu_data),
      .fu_rob   (fu_rob),
      .wb_valid (wb_valid),
      .wb_preg  (wb_preg),
      .wb_data  (wb_data),
      .wb_rob   (wb_rob)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_fu(input int i, input logic [6:0] p, input logic [31:0] d,
                           input logic [5:0] r);
      fu_valid[i]       = 1'b1;
      fu_preg[i*7 +: 7] = p;
      fu_data[i*32 +: 32] = d;
      fu_rob[i*6 +: 6]  = r;
   endtask

   function automatic logic [6:0]  wbp(input int k); return wb_preg[k*7 +: 7];   endfunction
   function automatic logic [31:0] wbd(input int k); return wb_data[k*32 +: 32]; endfunction
   function automatic logic [5:0]  wbr(input int k); return wb_rob[k*6 +: 6];    endfunction

   // Stream bookkeeping: data word = {fu id, per-FU sequence number}.
   int seq_acc  [4];
   int exp_next [4];
   int n_unacc;
   int n_full3;
   logic saw_stall;

   task automatic monitor_stream();
      int f;
      int s;
      for (int k = 0; k < 3; k++) begin
         if (wb_valid[k]) begin
            f = int'(wbd(k)[31:24]);
            s = int'(wbd(k)[23:0]);
            if (f > 3) begin
               chk("bp_fu_id", 64'(f), 64'(0));
            end else begin
               chk("bp_order", 64'(s), 64'(exp_next[f]));
               chk("bp_preg", 64'(wbp(k)), 64'(f));
               exp_next[f] = s + 1;
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; fu_valid = '0;
      fu_preg = '0; fu_data = '0; fu_rob = '0;

      // ---- reset ----
      step(); step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_wb_valid", 64'(wb_valid), 64'h0);
      chk("rst_fu_ready", 64'(fu_ready), 64'hf);
      chk("rst_rr_ptr", 64'(dut.rr_ptr), 64'h0);
      chk("rst_wb_data", 64'(wb_data[31:0]), 64'h0);

      // ---- single result: FU0 in cycle 1, visible in cycle 3 ----
      step();
      drive_fu(0, 7'd5, 32'hDEADBEEF, 6'd3);
      step();
      fu_valid = '0;
      @(negedge clk);
      chk("single_c2_valid", 64'(wb_valid), 64'h0);
      step();
      @(negedge clk);
      chk("single_valid", 64'(wb_valid), 64'h1);
      chk("single_preg", 64'(wbp(0)), 64'd5);
      chk("single_data", 64'(wbd(0)), 64'hDEADBEEF);
      chk("single_rob", 64'(wbr(0)), 64'd3);
      chk("single_rr", 64'(dut.rr_ptr), 64'd1);
      step();
      @(negedge clk);
      chk("idle_valid", 64'(wb_valid), 64'h0);
      chk("idle_hold_data", 64'(wbd(0)), 64'hDEADBEEF);

      // flush to bring rr_ptr back to 0
      flush = 1'b1;
      step();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_rr_zero", 64'(dut.rr_ptr), 64'h0);

      // ---- oversubscription: 4 results, 3 ports ----
      for (int i = 0; i < 4; i++) drive_fu(i, 7'(10 + i), 32'hA000_0000 + i, 6'(20 + i));
      step();
      fu_valid = '0;
      @(negedge clk);
      chk("over_c2_valid", 64'(wb_valid), 64'h0);
      step();
      @(negedge clk);
      chk("over_c3_valid", 64'(wb_valid), 64'h7);
      for (int k = 0; k < 3; k++) begin
         chk("over_c3_preg", 64'(wbp(k)), 64'(10 + k));
         chk("over_c3_data", 64'(wbd(k)), 64'(32'hA000_0000 + k));
         chk("over_c3_rob", 64'(wbr(k)), 64'(20 + k));
      end
      chk("over_c3_rr", 64'(dut.rr_ptr), 64'd3);
      step();
      @(negedge clk);
      chk("over_c4_valid", 64'(wb_valid), 64'h1);
      chk("over_c4_preg", 64'(wbp(0)), 64'd13);
      chk("over_c4_data", 64'(wbd(0)), 64'hA000_0003);
      chk("over_c4_rr", 64'(dut.rr_ptr), 64'd0);
      step();
      @(negedge clk);
      chk("over_c5_valid", 64'(wb_valid), 64'h0);

      // ---- backpressure: all FUs valid for 20 cycles ----
      for (int i = 0; i < 4; i++) begin seq_acc[i] = 0; exp_next[i] = 0; end
      n_unacc = 0; n_full3 = 0; saw_stall = 1'b0;
      step();
      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < 4; i++)
            drive_fu(i, 7'(i), {8'(i), 24'(seq_acc[i])}, 6'(seq_acc[i]));
         @(negedge clk);
         monitor_stream();
         if (t >= 2 && wb_valid == 3'b111) n_full3++;
         for (int i = 0; i < 4; i++) begin
            if (fu_ready[i]) seq_acc[i]++;
            else begin n_unacc++; saw_stall = 1'b1; end
         end
         step();
      end
      fu_valid = '0;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         monitor_stream();
         step();
      end
      @(negedge clk);
      chk("bp_stall_seen", 64'(saw_stall), 64'h1);
      chk("bp_ports_busy", 64'(n_full3), 64'd18);
      chk("bp_written", 64'(exp_next[0] + exp_next[1] + exp_next[2] + exp_next[3]),
          64'(80 - n_unacc));
      for (int i = 0; i < 4; i++) chk("bp_per_fu", 64'(exp_next[i]), 64'(seq_acc[i]));
      chk("bp_drained_ready", 64'(fu_ready), 64'hf);
      chk("bp_drained_valid", 64'(wb_valid), 64'h0);

      // ---- flush: 8 offered results must never appear ----
      step();
      for (int i = 0; i < 4; i++) drive_fu(i, 7'(100 + i), 32'hF1F1_0000 + i, 6'(40 + i));
      step();
      flush = 1'b1;
      for (int i = 0; i < 4; i++) drive_fu(i, 7'(104 + i), 32'hF2F2_0000 + i, 6'(44 + i));
      step();
      flush = 1'b0;
      fu_valid = '0;
      @(negedge clk);
      chk("flush_valid", 64'(wb_valid), 64'h0);
      chk("flush_ready", 64'(fu_ready), 64'hf);
      chk("flush_rr", 64'(dut.rr_ptr), 64'h0);
      for (int t = 0; t < 5; t++) begin
         step();
         @(negedge clk);
         chk("flush_quiet", 64'(wb_valid), 64'h0);
      end

      // ---- reset mid-stream ----
      step();
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < 4; i++) drive_fu(i, 7'(60 + i), 32'h5555_0000 + t * 4 + i, 6'(i));
         step();
      end
      @(negedge clk);
      chk("rst_mid_pre", 64'(wb_valid), 64'h7);
      rst = 1'b1;
      step();
      rst = 1'b0;
      fu_valid = '0;
      @(negedge clk);
      chk("rst_mid_valid", 64'(wb_valid), 64'h0);
      chk("rst_mid_preg", 64'(wb_preg), 64'h0);
      chk("rst_mid_data", 64'(wb_data[63:0]), 64'h0);
      chk("rst_mid_data2", 64'(wb_data[95:64]), 64'h0);
      chk("rst_mid_rob", 64'(wb_rob), 64'h0);
      chk("rst_mid_ready", 64'(fu_ready), 64'hf);
      chk("rst_mid_rr", 64'(dut.rr_ptr), 64'h0);
      step();
      drive_fu(2, 7'd42, 32'h1234_5678, 6'd17);
      step();
      fu_valid = '0;
      @(negedge clk);
      chk("post_rst_c2_valid", 64'(wb_valid), 64'h0);
      step();
      @(negedge clk);
      chk("post_rst_valid", 64'(wb_valid), 64'h1);
      chk("post_rst_preg", 64'(wbp(0)), 64'd42);
      chk("post_rst_data", 64'(wbd(0)), 64'h1234_5678);
      chk("post_rst_rob", 64'(wbr(0)), 64'd17);
      step();
      @(negedge clk);
      chk("post_rst_quiet", 64'(wb_valid), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
